// File: rtl/multdiv_iter.sv
// Iterative multiplier/divider: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, followed by a single sign-fix cycle.
//
// state | meaning
// IDLE  | waiting for a request, ready_o=1
// CALC  | WIDTH iteration steps, counter counts down to 0
// FIX   | sign correction / special cases, result registered
// DONE  | result presented on valid_o until ready_i or kill_i
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       operator_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             kill_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  md_op_e             op_q;
  logic               a_neg_q, b_neg_q, div_zero_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mag_q;
  logic [WIDTH-1:0]   result_q;

  logic               accept;
  logic               is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
  logic [WIDTH-1:0]   abs_a_in, abs_b_in;
  logic               is_div_q;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_res;

  assign accept   = valid_i && ready_o;
  assign result_o = result_q;
  assign is_div_q = (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);

  // Operand sign decode and magnitudes; mode 10 behaves as 11 for MULH,
  // division is signed only for mode 11.
  always_comb begin
    is_div_in = operator_i[1];
    a_sgn_in  = 1'b0;
    b_sgn_in  = 1'b0;
    if (is_div_in) begin
      a_sgn_in = (signed_mode_i == 2'b11);
      b_sgn_in = (signed_mode_i == 2'b11);
    end else begin
      a_sgn_in = |signed_mode_i;
      b_sgn_in = signed_mode_i[1];
    end
    a_neg_in = a_sgn_in & op_a_i[WIDTH-1];
    b_neg_in = b_sgn_in & op_b_i[WIDTH-1];
    abs_a_in = a_neg_in ? -op_a_i : op_a_i;
    abs_b_in = b_neg_in ? -op_b_i : op_b_i;
  end

  // One iteration step. MUL: acc = {partial, multiplier}, shifted right.
  // DIV: acc = {remainder, dividend/quotient}, shifted left.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, mag_q};
    div_ge    = ~div_diff[WIDTH];
    if (is_div_q) begin
      acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Sign correction and divide-by-zero handling; signed overflow falls out
  // naturally from the magnitude arithmetic.
  always_comb begin
    prod    = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    quo     = acc_q[WIDTH-1:0];
    rem     = acc_q[2*WIDTH-1:WIDTH];
    fix_res = '0;
    case (op_q)
      MD_OP_MULL: fix_res = prod[WIDTH-1:0];
      MD_OP_MULH: fix_res = prod[2*WIDTH-1:WIDTH];
      MD_OP_DIV:  fix_res = div_zero_q ? '1 : ((a_neg_q ^ b_neg_q) ? -quo : quo);
      MD_OP_REM:  fix_res = a_neg_q ? -rem : rem;
      default:    fix_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs; kill_i wins over everything else.
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = CALC;
      end
      CALC: begin
        if (kill_i)              state_d = IDLE;
        else if (cnt_q == '0)    state_d = FIX;
      end
      FIX: begin
        state_d = kill_i ? IDLE : DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (kill_i || ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      op_q       <= MD_OP_MULL;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      acc_q      <= '0;
      mag_q      <= '0;
      result_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q      <= CW'(WIDTH-1);
            op_q       <= md_op_e'(operator_i);
            a_neg_q    <= a_neg_in;
            b_neg_q    <= b_neg_in;
            div_zero_q <= (op_b_i == '0);
            acc_q      <= {{WIDTH{1'b0}}, (is_div_in ? abs_a_in : abs_b_in)};
            mag_q      <= is_div_in ? abs_b_in : abs_a_in;
          end
        end
        CALC: begin
          if (!kill_i) begin
            acc_q <= acc_step;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          end
        end
        FIX: begin
          if (!kill_i) result_q <= fix_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Bench for multdiv_iter: directed vectors feed a scoreboard queue, a
// monitor pops and checks result and latency whenever valid_o rises.
module tb_multdiv_iter;

  localparam int W = 32;
  localparam logic [1:0] MULL = 2'd0, MULH = 2'd1, DIV = 2'd2, REM = 2'd3;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i, ready_o, kill_i, valid_o, ready_i;
  logic [1:0]   operator_i, signed_mode_i;
  logic [W-1:0] op_a_i, op_b_i, result_o;

  typedef struct {
    logic [W-1:0] res;
    int           acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic v_prev   = 1'b0;

  multdiv_iter #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .operator_i(operator_i), .signed_mode_i(signed_mode_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .kill_i(kill_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops one expected entry on each rising valid_o.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      v_prev = 1'b0;
    end else begin
      if (valid_o && !v_prev) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got result %h with no request pending", result_o);
        end else begin
          e = sb.pop_front();
          chk("result", result_o, e.res);
          chk("latency", W'(cyc - e.acc_cyc), W'(W + 1));
        end
      end
      v_prev = valid_o;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [1:0] mode,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input bit push);
    exp_t e;
    int n = 0;
    @(negedge clk_i);
    while (!ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got ready_o 0 expected 1");
    end
    valid_i = 1'b1; operator_i = op; signed_mode_i = mode; op_a_i = a; op_b_i = b;
    @(posedge clk_i);
    #1;
    e.res = exp;
    e.acc_cyc = cyc;
    if (push) sb.push_back(e);
    valid_i = 1'b0;
    operator_i = 2'($urandom); signed_mode_i = 2'($urandom);
    op_a_i = $urandom; op_b_i = $urandom;
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk_i);
    while (!valid_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!valid_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_timeout: got valid_o 0 expected 1");
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [1:0] mode,
                     input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
    issue(op, mode, a, b, exp, 1'b1);
    wait_valid();
    @(posedge clk_i);
    #1;
    chk("idle_after_done", {31'b0, ready_o}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_i = 1'b1; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1;
    operator_i = '0; signed_mode_i = '0; op_a_i = '0; op_b_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    rst_i = 1'b0;

    run(MULL, 2'b11, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run(MULH, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run(MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run(MULH, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(MULH, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run(MULH, 2'b00, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002);
    run(MULL, 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    run(MULL, 2'b00, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2);
    run(DIV,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
    run(REM,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
    run(DIV,  2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run(REM,  2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001);
    run(DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run(REM,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run(DIV,  2'b00, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF);
    run(REM,  2'b00, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234);
    run(DIV,  2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF);
    run(REM,  2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB);
    run(DIV,  2'b00, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E);
    run(REM,  2'b00, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002);
    run(DIV,  2'b00, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC);
    run(REM,  2'b01, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001);

    // Hold result in DONE with ready_i low; a second request must be refused.
    ready_i = 1'b0;
    issue(MULL, 2'b00, 32'd3, 32'd5, 32'd15, 1'b1);
    wait_valid();
    valid_i = 1'b1; operator_i = MULL; op_a_i = 32'd9; op_b_i = 32'd9;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'b0, valid_o}, 32'd1);
      chk("hold_result", result_o, 32'd15);
      chk("hold_ready", {31'b0, ready_o}, 32'd0);
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("hold_release_ready", {31'b0, ready_o}, 32'd1);
    chk("hold_release_valid", {31'b0, valid_o}, 32'd0);

    // Kill during CALC cycle 10.
    issue(DIV, 2'b00, 32'd1000, 32'd3, 32'd0, 1'b0);
    repeat (10) @(negedge clk_i);
    kill_i = 1'b1;
    @(posedge clk_i);
    #1;
    kill_i = 1'b0;
    chk("kill_ready", {31'b0, ready_o}, 32'd1);
    chk("kill_valid", {31'b0, valid_o}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) seen = 1'b1;
    end
    chk("kill_no_valid", {31'b0, seen}, 32'd0);
    run(DIV, 2'b00, 32'd1000, 32'd3, 32'd333);

    // Reset mid-CALC.
    issue(MULL, 2'b00, 32'd6, 32'd7, 32'd0, 1'b0);
    repeat (5) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_ready", {31'b0, ready_o}, 32'd1);
    chk("midrst_valid", {31'b0, valid_o}, 32'd0);
    chk("midrst_result", result_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    run(MULL, 2'b00, 32'd6, 32'd7, 32'd42);

    repeat (3) @(negedge clk_i);
    chk("sb_drained", W'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_iter.md
MULTDIV_ITER -- requirements
Module: multdiv_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be even and >= 4.
REQ-002 clk_i  input  1  clock; one clock, all state updates on rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-high.
REQ-004 valid_i  input  1  request valid.
REQ-005 ready_o  output  1  block can accept a request.
REQ-006 operator_i  input  2  md_op_e: MD_OP_MULL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM.
REQ-007 signed_mode_i  input  2  bit0 = op_a signed, bit1 = op_b signed.
REQ-008 op_a_i  input  WIDTH  multiplicand / dividend.
REQ-009 op_b_i  input  WIDTH  multiplier / divisor.
REQ-010 kill_i  input  1  abort in-flight operation (pipeline flush).
REQ-011 valid_o  output  1  result valid.
REQ-012 ready_i  input  1  consumer accepts result.
REQ-013 result_o  output  WIDTH  result.

Function
REQ-014 States SHALL be IDLE, CALC, FIX, DONE; encoded as a local enum.
REQ-015 ready_o SHALL be 1 only in IDLE; accept = valid_i && ready_o; operator, signed mode and operands captured on the accept edge.
REQ-016 Accept edge: IDLE -> CALC, iteration counter loaded with WIDTH-1.
REQ-017 CALC SHALL perform one shift-add (MUL) or restoring shift-subtract (DIV/REM) step per cycle on magnitudes; counter decrements; CALC -> FIX on the edge where counter is 0 (exactly WIDTH CALC cycles).
REQ-018 FIX SHALL apply sign correction for one cycle, then -> DONE.
REQ-019 valid_o SHALL be 1 only in DONE; result_o stable while valid_o=1 and ready_i=0.
REQ-020 DONE && ready_i -> IDLE on that edge; a new request is not accepted in the same cycle (ready_o=0 in DONE).
REQ-021 Latency: valid_o asserted exactly WIDTH+1 cycles after the accepting edge, independent of operand values.
REQ-022 MULL: low WIDTH bits of the 2*WIDTH-bit product; identical for all signed modes.
REQ-023 MULH: high WIDTH bits of the product; signed_mode 00 = MULHU, 01 = MULHSU (a signed), 11 = MULH; mode 10 SHALL be treated as 11.
REQ-024 DIV/REM signed when signed_mode_i == 11, else unsigned; quotient rounds toward zero; remainder takes sign of dividend.
REQ-025 Divide by zero: DIV result all ones; REM result = op_a; latency unchanged.
REQ-026 Signed overflow (op_a = most-negative, op_b = -1): DIV result = op_a; REM result = 0.
REQ-027 kill_i=1 in CALC, FIX or DONE: next state IDLE, valid_o=0 next cycle, no result delivered; kill_i in IDLE has no effect; kill_i takes priority over ready_i and counter expiry.
REQ-028 valid_i while not ready_o SHALL be ignored (no capture, no state change).
REQ-029 Operand inputs changing after accept SHALL NOT affect the result.

Reset
REQ-030 rst_i=1 asynchronously forces: state IDLE, counter 0, internal registers 0, ready_o=1, valid_o=0, result_o=0.
REQ-031 Reset mid-operation SHALL discard the operation; first request after deassertion behaves as from power-up.

Verification (WIDTH=32)
REQ-032 MULL 0x0000_0007 * 0xFFFF_FFFD, mode 11 -> result 0xFFFF_FFEB, valid_o 33 cycles after accept.
REQ-033 MULH 0xFFFF_FFFF * 0xFFFF_FFFF: mode 11 -> 0x0000_0000; mode 00 -> 0xFFFF_FFFE; mode 01 -> 0xFFFF_FFFF.
REQ-034 DIV -7 / 2 signed -> 0xFFFF_FFFD; REM -7 % 2 -> 0xFFFF_FFFF; DIV 0x8000_0000 / 0xFFFF_FFFF signed -> 0x8000_0000, REM -> 0.
REQ-035 DIV 0x1234 / 0 -> 0xFFFF_FFFF; REM 0x1234 % 0 -> 0x0000_1234; latency still 33.
REQ-036 Hold ready_i=0 for 5 cycles in DONE -> valid_o and result_o stable; second valid_i during DONE not accepted.
REQ-037 kill_i pulse at CALC cycle 10 -> IDLE next cycle, valid_o never rises; subsequent request returns correct result; rst_i pulse mid-CALC -> outputs at reset values immediately.
